// File: rtl/lighting_pkg.sv
// Shared types and defaults for the lamp mode controller and its presence debouncer.
package lighting_pkg;

    typedef enum logic [1:0] {
        AUTO_OFF   = 2'd0,
        AUTO_ON    = 2'd1,
        MANUAL_OFF = 2'd2,
        MANUAL_ON  = 2'd3
    } lamp_state_t;

    localparam int unsigned AUTO_OFF_T_DEF  = 30000;
    localparam int unsigned PRESENCE_DB_DEF = 300;
    localparam int unsigned CNT_W_DEF       = 16;

    // Lamp output level for a given state.
    function automatic logic state_lamp(input lamp_state_t s);
        return (s == AUTO_ON) || (s == MANUAL_ON);
    endfunction

    // Auto-mode flag for a given state.
    function automatic logic state_auto(input lamp_state_t s);
        return (s == AUTO_OFF) || (s == AUTO_ON);
    endfunction

endpackage

// File: rtl/lamp_mode_ctrl_if.sv
// Button-event / presence / lamp-status bundle between the producers and the lamp controller.
interface lamp_mode_ctrl_if;

    logic a_evt;
    logic b_evt;
    logic presence;
    logic lamp;
    logic auto_mode;
    logic timer_active;

    modport master (
        output a_evt,
        output b_evt,
        output presence,
        input  lamp,
        input  auto_mode,
        input  timer_active
    );

    modport slave (
        input  a_evt,
        input  b_evt,
        input  presence,
        output lamp,
        output auto_mode,
        output timer_active
    );

endinterface

// File: rtl/presence_debounce.sv
// Two-flop synchronizer followed by a stability debouncer for the raw presence sensor.
module presence_debounce
    import lighting_pkg::*;
#(
    parameter int unsigned PRESENCE_DB = PRESENCE_DB_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic presence,
    output logic pres_db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESENCE_DB - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_pres_db;
    logic [CNT_W-1:0] r_cnt;

    // Counter tracks how long the synchronized level has disagreed with pres_db.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_pres_db <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= presence;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_pres_db) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_LAST) begin
                r_pres_db <= r_sync2;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign pres_db = r_pres_db;

endmodule

// File: rtl/lamp_mode_ctrl.sv
// Lamp mode FSM: manual toggle via B, auto presence/timeout control, A switches modes.
module lamp_mode_ctrl
    import lighting_pkg::*;
#(
    parameter int unsigned AUTO_OFF_T  = AUTO_OFF_T_DEF,
    parameter int unsigned PRESENCE_DB = PRESENCE_DB_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    lamp_mode_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(AUTO_OFF_T);
    localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

    lamp_state_t      r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_lamp;
    logic             r_auto;
    logic             r_timer_active;
    logic             w_pres_db;

    presence_debounce #(
        .PRESENCE_DB (PRESENCE_DB),
        .CNT_W       (CNT_W)
    ) u_presence_debounce (
        .clk      (clk),
        .rst      (rst),
        .presence (bus.presence),
        .pres_db  (w_pres_db)
    );

    // Outputs are recomputed from the target state on every transition; a_evt beats b_evt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= AUTO_OFF;
            r_timer        <= '0;
            r_lamp         <= 1'b0;
            r_auto         <= 1'b1;
            r_timer_active <= 1'b0;
        end else begin
            r_timer_active <= 1'b0;
            r_lamp         <= state_lamp(r_state);
            r_auto         <= state_auto(r_state);
            case (r_state)
                AUTO_OFF: begin
                    r_timer <= '0;
                    if (bus.a_evt) begin
                        r_state <= MANUAL_OFF;
                        r_lamp  <= state_lamp(MANUAL_OFF);
                        r_auto  <= state_auto(MANUAL_OFF);
                    end else if (w_pres_db) begin
                        r_state <= AUTO_ON;
                        r_timer <= TIMER_LOAD;
                        r_lamp  <= state_lamp(AUTO_ON);
                        r_auto  <= state_auto(AUTO_ON);
                    end
                end
                AUTO_ON: begin
                    if (bus.a_evt) begin
                        r_state <= MANUAL_ON;
                        r_timer <= '0;
                        r_lamp  <= state_lamp(MANUAL_ON);
                        r_auto  <= state_auto(MANUAL_ON);
                    end else if (w_pres_db) begin
                        r_timer <= TIMER_LOAD;
                    end else if (r_timer <= TIMER_ONE) begin
                        // A zero timer here is unreachable; treat it as expired rather than wrap.
                        r_state <= AUTO_OFF;
                        r_timer <= '0;
                        r_lamp  <= state_lamp(AUTO_OFF);
                        r_auto  <= state_auto(AUTO_OFF);
                    end else begin
                        r_timer        <= r_timer - TIMER_ONE;
                        r_timer_active <= 1'b1;
                    end
                end
                MANUAL_OFF: begin
                    r_timer <= '0;
                    if (bus.a_evt) begin
                        r_state <= AUTO_OFF;
                        r_lamp  <= state_lamp(AUTO_OFF);
                        r_auto  <= state_auto(AUTO_OFF);
                    end else if (bus.b_evt) begin
                        r_state <= MANUAL_ON;
                        r_lamp  <= state_lamp(MANUAL_ON);
                        r_auto  <= state_auto(MANUAL_ON);
                    end
                end
                MANUAL_ON: begin
                    r_timer <= '0;
                    if (bus.a_evt) begin
                        r_state <= AUTO_OFF;
                        r_lamp  <= state_lamp(AUTO_OFF);
                        r_auto  <= state_auto(AUTO_OFF);
                    end else if (bus.b_evt) begin
                        r_state <= MANUAL_OFF;
                        r_lamp  <= state_lamp(MANUAL_OFF);
                        r_auto  <= state_auto(MANUAL_OFF);
                    end
                end
                default: begin
                    r_state <= AUTO_OFF;
                    r_timer <= '0;
                    r_lamp  <= state_lamp(AUTO_OFF);
                    r_auto  <= state_auto(AUTO_OFF);
                end
            endcase
        end
    end

    assign bus.lamp         = r_lamp;
    assign bus.auto_mode    = r_auto;
    assign bus.timer_active = r_timer_active;

endmodule

// File: tb/tb_lamp_mode_ctrl.sv
// Self-checking bench for lamp_mode_ctrl with AUTO_OFF_T=20, PRESENCE_DB=4.
module tb_lamp_mode_ctrl;

    typedef struct packed {
        logic lamp;
        logic auto_m;
        logic ta;
    } outs_t;

    typedef struct {
        logic  a;
        logic  b;
        logic  p;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    lamp_mode_ctrl_if bus ();

    lamp_mode_ctrl #(
        .AUTO_OFF_T  (20),
        .PRESENCE_DB (4),
        .CNT_W       (16)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    outs_t sb_q[$];
    string nm_q[$];
    int    n_pass   = 0;
    int    n_checks = 0;

    function automatic outs_t actual();
        return {bus.lamp, bus.auto_mode, bus.timer_active};
    endfunction

    task automatic check(input string nm, input outs_t got, input outs_t exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s @%0t: lamp/auto/timer_active got %b required %b", nm, $time, got, exp);
        else
            n_pass++;
    endtask

    // Drive one cycle of inputs, queue the expected outputs for the cycle after the next edge.
    task automatic cyc(input logic a, input logic b, input logic p, input outs_t exp, input string nm);
        outs_t e;
        string n;
        bus.a_evt    = a;
        bus.b_evt    = b;
        bus.presence = p;
        sb_q.push_back(exp);
        nm_q.push_back(nm);
        @(negedge clk);
        e = sb_q.pop_front();
        n = nm_q.pop_front();
        check(n, actual(), e);
    endtask

    task automatic do_reset(input logic p);
        rst_n        = 1'b0;
        bus.a_evt    = 1'b0;
        bus.b_evt    = 1'b0;
        bus.presence = p;
        @(negedge clk);
        check("reset_state", actual(), 3'b010);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[12];

    initial begin
        int n;
        rst_n        = 1'b0;
        bus.a_evt    = 1'b0;
        bus.b_evt    = 1'b0;
        bus.presence = 1'b0;

        // Manual-mode toggling and simultaneous-event priority; presence held low.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'b000};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'b100};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'b100};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'b000};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'b010};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'b010};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'b000};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b010};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'b000};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 3'b100};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b010};

        // Test 1: idle in auto mode with no presence.
        do_reset(1'b0);
        for (int c = 0; c < 50; c++) cyc(1'b0, 1'b0, 1'b0, 3'b010, "t1_idle");

        // Test 2: presence window 10..39, lamp 17..65, countdown visible 47..65.
        do_reset(1'b0);
        for (int c = 0; c <= 70; c++) begin
            n = c + 1;
            cyc(1'b0, 1'b0, (c >= 10 && c < 40),
                {(n >= 17 && n <= 65), 1'b1, (n >= 47 && n <= 65)}, "t2_timeout");
        end

        // Test 3: short presence dropout restarts the timer; lamp never drops.
        do_reset(1'b0);
        for (int c = 0; c <= 60; c++) begin
            n = c + 1;
            cyc(1'b0, 1'b0, !(c >= 20 && c < 30),
                {(n >= 7), 1'b1, (n >= 27 && n <= 36)}, "t3_restart");
        end

        // Tests 4/5: table of manual-mode vectors.
        do_reset(1'b0);
        for (int i = 0; i < 12; i++)
            cyc(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].exp, $sformatf("t4_vec%0d", i));

        // Test 5b: a+b in MANUAL_OFF with presence debounced high.
        do_reset(1'b0);
        cyc(1'b1, 1'b0, 1'b1, 3'b000, "t5_to_manual");
        for (int c = 1; c < 10; c++) cyc(1'b0, 1'b0, 1'b1, 3'b000, "t5_manual_hold");
        cyc(1'b1, 1'b1, 1'b1, 3'b010, "t5_ab_to_auto_off");
        cyc(1'b0, 1'b0, 1'b1, 3'b110, "t5_auto_on_next");
        cyc(1'b1, 1'b0, 1'b1, 3'b100, "t5_auto_on_to_manual_on");
        cyc(1'b1, 1'b0, 1'b1, 3'b010, "t5_manual_on_to_auto_off");
        cyc(1'b0, 1'b0, 1'b1, 3'b110, "t5_reenter_auto_on");
        cyc(1'b0, 1'b1, 1'b1, 3'b110, "t5_b_ignored_auto_on");

        // Test 6: async reset with the timer at 12, then a fresh debounce.
        do_reset(1'b0);
        for (int c = 0; c <= 33; c++) begin
            n = c + 1;
            cyc(1'b0, 1'b0, (c < 20), {(n >= 7), 1'b1, (n >= 27)}, "t6_countdown");
        end
        bus.presence = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_rst_immediate", actual(), 3'b010);
        @(posedge clk);
        #1;
        check("t6_async_rst_held", actual(), 3'b010);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            n = c + 1;
            cyc(1'b0, 1'b0, 1'b1, {(n >= 7), 1'b1, 1'b0}, "t6_after_release");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
